// File: rtl/dac_pkg.sv
// Shared helpers for the DAC driver: midscale code, sample-format conversion
// and the accepted TYPE strings.
`timescale 1ns/1ps
package dac_pkg;

   localparam string TYPE_UNSIGNED = "unsigned";
   localparam string TYPE_SIGNED   = "signed";

   // Midscale offset-binary code for a given resolution: 1 followed by zeros.
   function automatic logic [31:0] midscale(input int bits);
      return 32'(1) << (bits - 1);
   endfunction

   // Two's complement -> offset binary is an MSB flip; offset binary passes through.
   function automatic logic [31:0] to_offset(input logic [31:0] data, input int bits,
                                             input logic is_signed);
      if (is_signed) return data ^ midscale(bits);
      return data;
   endfunction

endpackage

// File: rtl/dac_fifo.sv
// Synchronous FIFO holding offset-binary sample codes between the stream
// input and the conversion strobe. Occupancy is tracked separately from the
// pointers so a full FIFO is distinguishable from an empty one.
`timescale 1ns/1ps
module dac_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         wr_en,
   input  logic [W-1:0]                 wr_data,
   input  logic                         rd_en,
   output logic [W-1:0]                 rd_data,
   output logic [$clog2(DEPTH+1)-1:0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          wr_ok;
   logic          rd_ok;

   // Writes never land in a full FIFO and reads never leave an empty one.
   assign wr_ok   = wr_en && (level < LW'(DEPTH));
   assign rd_ok   = rd_en && (level != '0);
   assign rd_data = mem[rd_ptr];

   // Storage array: data only, no reset needed.
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= wr_data;
   end

   // Pointers wrap naturally at DEPTH; level counts net pushes minus pops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
         if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
         case ({wr_ok, rd_ok})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/dac_driver.sv
// DAC driver: buffers stream samples in a FIFO, releases one per conversion
// strobe into a fixed-latency output pipeline, and presents both the digital
// code and a real-valued analog model scaled as the inverse of adc_sim.
`timescale 1ns/1ps
module dac_driver
   import dac_pkg::*;
#(
   parameter int    BITS  = 8,
   parameter real   VPP   = 1.0,
   parameter int    PIPE  = 5,
   parameter string TYPE  = "unsigned",
   parameter int    DEPTH = 8,
   parameter int    DIV   = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [BITS-1:0]              in_data,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic [BITS-1:0]              code,
   output real                          out,
   output logic                         underrun,
   output logic [15:0]                  underrun_cnt
);

   localparam int              LW        = $clog2(DEPTH+1);
   localparam int              CW        = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0]   CNT_LAST  = CW'(DIV - 1);
   localparam logic [BITS-1:0] MID       = BITS'(midscale(BITS));
   localparam bit              IS_SIGNED = (TYPE == TYPE_SIGNED);
   localparam real             SCALE     = VPP / (2.0 ** BITS);

   logic [CW-1:0]   cnt;
   logic            strobe;
   logic            push;
   logic            pop;
   logic [BITS-1:0] wr_code;
   logic [BITS-1:0] head;
   logic [BITS-1:0] pipe [PIPE];

   // Saturating increment so the underrun counter sticks at all-ones.
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Ready reflects occupancy only; a same-cycle pop never opens a slot.
   assign in_ready = rst_n && (level < LW'(DEPTH));
   assign push     = in_valid && in_ready;
   assign strobe   = (cnt == CNT_LAST);
   // Pop decision uses registered level, so a push into an empty FIFO waits a strobe.
   assign pop      = strobe && (level != '0);
   assign underrun = rst_n && strobe && (level == '0);
   assign wr_code  = BITS'(to_offset(32'(in_data), BITS, IS_SIGNED));
   assign code     = pipe[PIPE-1];

   dac_fifo #(
      .W     (BITS),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (push),
      .wr_data (wr_code),
      .rd_en   (pop),
      .rd_data (head),
      .level   (level)
   );

   // Conversion strobe counter: 0..DIV-1, strobe in the last count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      cnt <= '0;
      else if (strobe) cnt <= '0;
      else             cnt <= cnt + CW'(1);
   end

   // Underrun event counter, saturating.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        underrun_cnt <= '0;
      else if (underrun) underrun_cnt <= sat_inc(underrun_cnt);
   end

   // Output pipeline: stage 0 loads on a pop (holds on underrun), later stages shift every clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < PIPE; i++) pipe[i] <= MID;
      end else begin
         if (pop) pipe[0] <= head;
         for (int i = 1; i < PIPE; i++) pipe[i] <= pipe[i-1];
      end
   end

   // Analog model: offset-binary code mapped onto a VPP span centred on zero.
   always_comb begin
      out = real'(code) * SCALE - VPP / 2.0;
   end

endmodule

// File: tb/tb_dac_driver.sv
// Directed bench for dac_driver: reset, unsigned and signed formats, FIFO
// fill/back-pressure and ordering, underrun with counter saturation,
// analog-model loopback quantisation, and reset in mid-stream.
`timescale 1ns/1ps
module tb_dac_driver;

   logic        clk;
   logic        rst_n, rst_ns;
   logic [7:0]  u_data, s_data, t_data;
   logic        u_valid, s_valid, t_valid;
   logic        u_ready, s_ready, t_ready;
   logic [3:0]  u_level, s_level, t_level;
   logic [7:0]  u_code, s_code, t_code;
   real         u_out, s_out, t_out;
   logic        u_urun, s_urun, t_urun;
   logic [15:0] u_ucnt, s_ucnt, t_ucnt;

   int n_cmp = 0;
   int n_bad = 0;

   dac_driver u_dut (
      .clk(clk), .rst_n(rst_n), .in_data(u_data), .in_valid(u_valid), .in_ready(u_ready),
      .level(u_level), .code(u_code), .out(u_out), .underrun(u_urun), .underrun_cnt(u_ucnt));

   dac_driver #(.TYPE("signed")) s_dut (
      .clk(clk), .rst_n(rst_n), .in_data(s_data), .in_valid(s_valid), .in_ready(s_ready),
      .level(s_level), .code(s_code), .out(s_out), .underrun(s_urun), .underrun_cnt(s_ucnt));

   dac_driver #(.DIV(1)) t_dut (
      .clk(clk), .rst_n(rst_ns), .in_data(t_data), .in_valid(t_valid), .in_ready(t_ready),
      .level(t_level), .code(t_code), .out(t_out), .underrun(t_urun), .underrun_cnt(t_ucnt));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_real(input string tag, input real obs, input real exp);
      n_cmp++;
      assert ((obs - exp) < 1.0e-9 && (exp - obs) < 1.0e-9) else begin
         n_bad++;
         $error("FAIL %s: observed %f expected %f", tag, obs, exp);
      end
   endtask

   // Ideal 8-bit, 1.0 Vpp ADC quantiser: inverse of the DAC analog model.
   function automatic logic [31:0] quant(input real v);
      return 32'($rtoi($floor((v + 0.5) * 256.0)));
   endfunction

   initial begin
      int         idx;
      int         ramp;
      int         nxt;
      logic       acc;
      logic [7:0] prev;

      rst_n = 1'b0; rst_ns = 1'b0;
      u_valid = 1'b0; u_data = '0;
      s_valid = 1'b0; s_data = '0;
      t_valid = 1'b0; t_data = '0;

      // Reset state
      repeat (3) tick();
      chk("rst_code", u_code, 32'h80);
      chk_real("rst_out", u_out, 0.0);
      chk("rst_level", u_level, 0);
      chk("rst_ready", u_ready, 0);
      chk("rst_ucnt", u_ucnt, 0);
      chk("rst_urun", u_urun, 0);
      rst_n = 1'b1; rst_ns = 1'b1;
      #1;
      chk("ready_release", u_ready, 1);

      // Unsigned and signed pushes, back-to-back (edges E1..E3)
      u_valid = 1'b1; u_data = 8'h00; s_valid = 1'b1; s_data = 8'h80;
      tick();
      u_data = 8'hFF; s_data = 8'h00;
      tick();
      u_data = 8'h40; s_data = 8'h7F;
      tick();
      u_valid = 1'b0; s_valid = 1'b0;
      chk("level3", u_level, 3);
      repeat (4) tick();                       // E7
      chk("code_pre", u_code, 32'h80);
      tick();                                  // E8
      chk("code_00", u_code, 32'h00);
      chk_real("out_00", u_out, -0.5);
      chk("s_code_00", s_code, 32'h00);
      chk("t_cnt8", t_ucnt, 8);
      repeat (3) tick();                       // E11
      chk("code_00_hold", u_code, 32'h00);
      tick();                                  // E12
      chk("code_FF", u_code, 32'hFF);
      chk_real("out_FF", u_out, 0.49609375);
      chk("s_code_80", s_code, 32'h80);
      repeat (3) tick();                       // E15
      chk("urun_first", u_urun, 1);
      chk("code_FF_hold", u_code, 32'hFF);
      tick();                                  // E16
      chk("code_40", u_code, 32'h40);
      chk_real("out_40", u_out, -0.25);
      chk("s_code_FF", s_code, 32'hFF);
      chk("urun_low", u_urun, 0);
      chk("ucnt1", u_ucnt, 1);
      chk("t_cnt16", t_ucnt, 16);
      repeat (3) tick();                       // E19
      chk("urun_second", u_urun, 1);
      tick();                                  // E20
      chk("ucnt2", u_ucnt, 2);
      chk("code_40_hold", u_code, 32'h40);

      // Fill: valid held 12 clocks, data advances only on a handshake
      idx = 0;
      u_valid = 1'b1;
      for (int i = 0; i < 12; i++) begin
         u_data = 8'(8'h10 + idx);
         acc = u_ready;
         tick();                               // E21+i
         if (acc) idx++;
         if (i == 7) chk("fill_d0", u_code, 32'h10);
         if (i == 9) begin
            chk("fill_full_level", u_level, 8);
            chk("fill_full_ready", u_ready, 0);
         end
      end
      u_valid = 1'b0;                          // E32
      chk("fill_accepted", idx, 10);
      chk("fill_d1", u_code, 32'h11);
      for (int k = 2; k < 10; k++) begin
         repeat (4) tick();
         chk("fill_order", u_code, 32'(8'h10 + k));
      end
      chk("fill_ucnt3", u_ucnt, 3);            // E64
      chk("fill_empty", u_level, 0);

      // Loopback ramp through the analog model
      ramp = 0; nxt = 0; prev = u_code;
      u_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         u_data = 8'(ramp);
         acc = u_ready;
         tick();
         if (acc) ramp++;
         chk("loop_quant", quant(u_out), 32'(u_code));
         if (u_code !== prev) begin
            chk("ramp_seq", u_code, 32'(nxt));
            nxt++;
            prev = u_code;
         end
      end
      chk("ramp_progress", 32'(nxt >= 40), 1);

      // Reset in mid-stream
      rst_n = 1'b0;
      #1;
      chk("mid_code", u_code, 32'h80);
      chk_real("mid_out", u_out, 0.0);
      chk("mid_level", u_level, 0);
      chk("mid_ready", u_ready, 0);
      chk("mid_ucnt", u_ucnt, 0);
      u_valid = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (3) tick();
      chk("post_urun", u_urun, 1);
      chk("post_code", u_code, 32'h80);
      tick();
      chk("post_ucnt", u_ucnt, 1);
      chk("post_level", u_level, 0);

      // Saturation on the DIV=1 instance
      repeat (65600) tick();
      chk("sat_ucnt", t_ucnt, 32'hFFFF);
      chk("sat_urun", t_urun, 1);
      chk("sat_code", t_code, 32'h80);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
